// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the AHB seven-segment display slave.
//   - Word offsets of the four registers (HADDR[3:2])
//   - CTRL bit-field positions
//   - AHB HTRANS encodings
//   - Active-low segment patterns (a..g = bits 0..6) for hex digits 0-F
//   - disp_regs_t: one full register set (shadow or active copy)
package display_pkg;

   // Register word offsets, as seen on HADDR[3:2]
   localparam logic [1:0] ADDR_DIG_LO = 2'd0;
   localparam logic [1:0] ADDR_DIG_HI = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_COMMIT = 2'd3;

   // CTRL bit fields
   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_DP_LSB    = 8;
   localparam int unsigned CTRL_BLANK_LSB = 16;

   // AHB transfer types
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // Active-low segment patterns, gfedcba
   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   localparam logic [7:0] SEG_ALL_OFF = 8'hFF;
   localparam logic [7:0] DIGITS_OFF  = 8'hFF;

   typedef struct packed {
      logic [31:0] digits;  // digit i in [4*i+3:4*i]
      logic [7:0]  blank;
      logic [7:0]  dp;
      logic        en;
   } disp_regs_t;

endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational hex to active-low seven-segment decoder.
//   hex_i [3:0]  hex digit value
//   seg_o [6:0]  active-low segments, a..g = bits 0..6
module seven_seg_decode
   import display_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_HEX_0;
      unique case (hex_i)
         4'h0: seg_o = SEG_HEX_0;
         4'h1: seg_o = SEG_HEX_1;
         4'h2: seg_o = SEG_HEX_2;
         4'h3: seg_o = SEG_HEX_3;
         4'h4: seg_o = SEG_HEX_4;
         4'h5: seg_o = SEG_HEX_5;
         4'h6: seg_o = SEG_HEX_6;
         4'h7: seg_o = SEG_HEX_7;
         4'h8: seg_o = SEG_HEX_8;
         4'h9: seg_o = SEG_HEX_9;
         4'hA: seg_o = SEG_HEX_A;
         4'hB: seg_o = SEG_HEX_B;
         4'hC: seg_o = SEG_HEX_C;
         4'hD: seg_o = SEG_HEX_D;
         4'hE: seg_o = SEG_HEX_E;
         4'hF: seg_o = SEG_HEX_F;
      endcase
   end

endmodule

// File: rtl/ahb_seg_display.sv
// ahb_seg_display: AHB-Lite slave driving an eight-digit multiplexed seven-segment display.
// Software writes shadow registers and requests a commit; the shadow set is copied into the
// active set at the next frame boundary, so a frame never shows a half-updated display.
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   HADDR/HWDATA/HSIZE/HTRANS/
//   HWRITE/HREADY/HSEL           AHB-Lite slave inputs (HADDR[3:2] decoded, HSIZE ignored)
//   HRDATA, HREADYOUT            read data (0 outside read data phases), always ready
//   nDigit [7:0]                 active-low digit enables, bit i = digit i
//   nSeg   [7:0]                 active-low segments a..g = bits 0..6, dp = bit 7
module ahb_seg_display
   import display_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4096,  // cycles per digit slot
   parameter int unsigned BLANK   = 16     // dark cycles at the start of each slot
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic        HSEL,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic [7:0]  nDigit,
   output logic [7:0]  nSeg
);

   localparam int unsigned PreW = $clog2(CLK_DIV);
   localparam logic [PreW-1:0] PreLast  = PreW'(CLK_DIV - 1);
   localparam logic [PreW-1:0] PreBlank = PreW'(BLANK);

   logic            wr_q, rd_q;
   logic [1:0]      addr_q;
   disp_regs_t      shadow_q, shadow_d, active_q, active_d;
   logic            pending_q, pending_d;
   logic [PreW-1:0] presc_q, presc_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      ndigit_q, ndigit_d, nseg_q, nseg_d;
   logic            slot_end, frame_end, commit_wr;
   logic [3:0]      cur_hex;
   logic [6:0]      seg_raw;

   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:24]};

   assign HREADYOUT = 1'b1;
   assign nDigit    = ndigit_q;
   assign nSeg      = nseg_q;

   // Address phase capture; write data follows in the next cycle
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         addr_q <= 2'd0;
      end else if (HREADY) begin
         wr_q   <= HSEL && (HTRANS != HTRANS_IDLE) && HWRITE;
         rd_q   <= HSEL && (HTRANS != HTRANS_IDLE) && !HWRITE;
         addr_q <= HADDR[3:2];
      end
   end

   always_comb begin
      shadow_d  = shadow_q;
      commit_wr = 1'b0;
      if (wr_q) begin
         case (addr_q)
            ADDR_DIG_LO: shadow_d.digits[15:0]  = HWDATA[15:0];
            ADDR_DIG_HI: shadow_d.digits[31:16] = HWDATA[15:0];
            ADDR_CTRL: begin
               shadow_d.en    = HWDATA[CTRL_EN_BIT];
               shadow_d.dp    = HWDATA[CTRL_DP_LSB +: 8];
               shadow_d.blank = HWDATA[CTRL_BLANK_LSB +: 8];
            end
            default: commit_wr = 1'b1;
         endcase
      end
   end

   always_comb begin
      HRDATA = 32'd0;
      if (rd_q) begin
         case (addr_q)
            ADDR_DIG_LO: HRDATA = {16'd0, shadow_q.digits[15:0]};
            ADDR_DIG_HI: HRDATA = {16'd0, shadow_q.digits[31:16]};
            ADDR_CTRL:   HRDATA = {8'd0, shadow_q.blank, shadow_q.dp, 7'd0, shadow_q.en};
            default:     HRDATA = {28'd0, idx_q, pending_q};
         endcase
      end
   end

   // Scan counters and frame-boundary commit
   always_comb begin
      slot_end  = (presc_q == PreLast);
      frame_end = slot_end && (idx_q == 3'd7);
      presc_d   = slot_end ? '0 : presc_q + 1'b1;
      idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
      active_d  = (frame_end && pending_q) ? shadow_q : active_q;
      // A commit landing on the boundary itself waits for the next one; a repeat commit
      // while already pending is absorbed.
      pending_d = (pending_q && !frame_end) || (commit_wr && !pending_q);
   end

   assign cur_hex = active_q.digits[{idx_q, 2'b00} +: 4];

   seven_seg_decode u_decode (
      .hex_i (cur_hex),
      .seg_o (seg_raw)
   );

   always_comb begin
      ndigit_d = DIGITS_OFF;
      nseg_d   = SEG_ALL_OFF;
      if (active_q.en && (presc_q >= PreBlank)) begin
         ndigit_d = ~(8'd1 << idx_q);
         if (!active_q.blank[idx_q]) begin
            nseg_d = {~active_q.dp[idx_q], seg_raw};
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         presc_q   <= '0;
         idx_q     <= 3'd0;
         ndigit_q  <= DIGITS_OFF;
         nseg_q    <= SEG_ALL_OFF;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         ndigit_q  <= ndigit_d;
         nseg_q    <= nseg_d;
      end
   end

endmodule

// File: tb/tb_ahb_seg_display.sv
// tb_ahb_seg_display: scoreboard bench for ahb_seg_display at CLK_DIV=8, BLANK=2.
// Stimulus pushes expected read data / display values into queues; a negedge monitor pops
// and compares whenever a read data phase or a display probe is flagged.
module tb_ahb_seg_display;
   import display_pkg::*;

   localparam int unsigned CLK_DIV = 8;
   localparam int unsigned BLANK   = 2;
   localparam int unsigned FRAME   = 8 * CLK_DIV;

   // Active-low patterns with dp off, hand-tabulated
   localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82,
                                          8'hF8, 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1,
                                          8'h86, 8'h8E};

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b0;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        HWRITE, HREADY, HSEL, HREADYOUT;
   logic [7:0]  nDigit, nSeg;

   always #5 HCLK = ~HCLK;

   ahb_seg_display #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HSIZE     (HSIZE),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HSEL      (HSEL),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .nDigit    (nDigit),
      .nSeg      (nSeg)
   );

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        rd_exp_q[$];
   exp_t        disp_exp_q[$];
   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   logic        rd_dphase = 1'b0;
   logic        probe = 1'b0;

   // Cycles since reset release; equals the scan position (prescaler + 8*index)
   int unsigned ncyc;
   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) ncyc <= 0;
      else        ncyc <= ncyc + 1;
   end

   // Model of shadow and active sets around the single outstanding commit
   logic [31:0] sh_dig, sh_ctrl, old_dig, old_ctrl, new_dig, new_ctrl;
   int unsigned cmt_c, cmt_b;

   function automatic logic [15:0] disp_exp(int unsigned n);
      logic [31:0] dig, ctrl;
      int unsigned m, pre, idx;
      logic [15:0] r;
      if (n == 0) return 16'hFFFF;
      m = n - 1;  // outputs are registered from the previous cycle's state
      if (m >= cmt_b) begin dig = new_dig; ctrl = new_ctrl; end
      else            begin dig = old_dig; ctrl = old_ctrl; end
      pre = m % CLK_DIV;
      idx = (m / CLK_DIV) % 8;
      if (!ctrl[0] || pre < BLANK) return 16'hFFFF;
      r[15:8] = ~(8'd1 << idx);
      if (ctrl[16 + idx]) r[7:0] = 8'hFF;
      else begin
         r[7:0] = SEG_TAB[dig[4*idx +: 4]];
         r[7]   = ~ctrl[8 + idx];
      end
      return r;
   endfunction

   function automatic logic [31:0] status_exp(int unsigned n);
      logic [2:0] ix;
      logic       pend;
      ix   = 3'((n / CLK_DIV) % 8);
      pend = (n > cmt_c) && (n < cmt_b);
      return {28'd0, ix, pend};
   endfunction

   task automatic model_reset();
      sh_dig = 0; sh_ctrl = 0; old_dig = 0; old_ctrl = 0; new_dig = 0; new_ctrl = 0;
      cmt_c = 0; cmt_b = 0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {28'd0, a, 2'b00};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = d;
      case (a)
         ADDR_DIG_LO: sh_dig[15:0]  = d[15:0];
         ADDR_DIG_HI: sh_dig[31:16] = d[15:0];
         ADDR_CTRL:   sh_ctrl       = d & 32'h00FF_FF01;
         default: begin
            old_dig = new_dig; old_ctrl = new_ctrl;
            new_dig = sh_dig;  new_ctrl = sh_ctrl;
            cmt_c = ncyc;
            cmt_b = ((ncyc + 2 + FRAME - 1) / FRAME) * FRAME;
         end
      endcase
   endtask

   task automatic bus_read(input logic [1:0] a, input string nm);
      exp_t e;
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {28'd0, a, 2'b00};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      e.name = nm;
      case (a)
         ADDR_DIG_LO: e.val = {16'd0, sh_dig[15:0]};
         ADDR_DIG_HI: e.val = {16'd0, sh_dig[31:16]};
         ADDR_CTRL:   e.val = sh_ctrl;
         default:     e.val = status_exp(ncyc);
      endcase
      if (HRESET) e.val = 32'd0;
      rd_exp_q.push_back(e);
      rd_dphase = 1'b1;
      @(negedge HCLK); #1;
      rd_dphase = 1'b0;
   endtask

   task automatic probe_disp(input string nm);
      exp_t e;
      @(posedge HCLK); #1;
      e.name = nm;
      e.val  = {16'd0, disp_exp(ncyc)};
      disp_exp_q.push_back(e);
      probe = 1'b1;
      @(negedge HCLK); #1;
      probe = 1'b0;
   endtask

   task automatic wait_commit();
      while (ncyc < cmt_b + 1) begin @(posedge HCLK); #1; end
   endtask

   task automatic wait_residue(input int unsigned r);
      while (ncyc % FRAME != r) begin @(posedge HCLK); #1; end
   endtask

   // Monitor / scoreboard
   always @(negedge HCLK) begin
      exp_t e;
      if (rd_dphase) begin
         n_chk = n_chk + 1;
         if (rd_exp_q.size() == 0) begin
            $display("FAIL rd_underflow: HRDATA=%h with nothing expected", HRDATA);
         end else begin
            e = rd_exp_q.pop_front();
            if (HRDATA === e.val) n_pass = n_pass + 1;
            else $display("FAIL %s @%0t: HRDATA=%h required %h", e.name, $time, HRDATA, e.val);
         end
      end
      if (probe) begin
         n_chk = n_chk + 1;
         if (disp_exp_q.size() == 0) begin
            $display("FAIL disp_underflow: nDigit=%h nSeg=%h with nothing expected", nDigit, nSeg);
         end else begin
            e = disp_exp_q.pop_front();
            if ({nDigit, nSeg} === e.val[15:0]) n_pass = n_pass + 1;
            else $display("FAIL %s @%0t: nDigit/nSeg=%h/%h required %h/%h", e.name, $time,
                          nDigit, nSeg, e.val[15:8], e.val[7:0]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HREADY = 1'b1;
      HADDR = 32'd0; HWDATA = 32'd0; HSIZE = 3'b010;
      model_reset();
      #2 HRESET = 1'b1;
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;

      // Reset state
      probe_disp("reset_display");
      bus_read(ADDR_DIG_LO, "reset_dig_lo");
      bus_read(ADDR_DIG_HI, "reset_dig_hi");
      bus_read(ADDR_CTRL, "reset_ctrl");
      bus_read(ADDR_COMMIT, "reset_status");

      // Write then commit
      bus_write(ADDR_DIG_LO, 32'h0000_3210);
      bus_write(ADDR_CTRL, 32'h0000_0001);
      bus_write(ADDR_COMMIT, 32'h0);
      bus_read(ADDR_COMMIT, "pending_set");
      bus_read(ADDR_CTRL, "ctrl_readback");
      wait_commit();
      repeat (FRAME) probe_disp("scan_3210");
      bus_read(ADDR_COMMIT, "pending_clear");

      // Shadow isolation
      bus_write(ADDR_DIG_LO, 32'h0000_8888);
      bus_read(ADDR_DIG_LO, "shadow_readback");
      repeat (3 * FRAME) probe_disp("shadow_isolation");

      // Commit whose data phase coincides with a frame boundary cycle
      wait_residue(FRAME - 3);
      bus_write(ADDR_COMMIT, 32'h0);
      bus_read(ADDR_COMMIT, "pending_coincident");
      while (ncyc < cmt_b + CLK_DIV) probe_disp("coincident_commit");

      // Decimal-point and blank masks
      bus_write(ADDR_CTRL, 32'h0002_0101);
      bus_write(ADDR_COMMIT, 32'h0);
      wait_commit();
      repeat (FRAME) probe_disp("masks");

      // Asynchronous reset mid-scan while a digit is lit
      wait_residue(4);
      @(posedge HCLK); #3;
      HRESET = 1'b1;
      model_reset();
      e.name = "reset_midscan";
      e.val  = 32'h0000_FFFF;
      disp_exp_q.push_back(e);
      probe = 1'b1;
      @(negedge HCLK); #1;
      probe = 1'b0;
      bus_read(ADDR_DIG_LO, "in_reset_dig_lo");
      bus_read(ADDR_COMMIT, "in_reset_status");
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      bus_read(ADDR_DIG_LO, "post_reset_dig_lo");
      bus_read(ADDR_DIG_HI, "post_reset_dig_hi");
      bus_read(ADDR_CTRL, "post_reset_ctrl");
      bus_read(ADDR_COMMIT, "post_reset_status");

      // Re-enable with new digits, then disable across a boundary
      bus_write(ADDR_DIG_LO, 32'h0000_00A1);
      bus_write(ADDR_CTRL, 32'h0000_0001);
      bus_write(ADDR_COMMIT, 32'h0);
      wait_commit();
      repeat (2 * CLK_DIV) probe_disp("reenable");
      bus_write(ADDR_CTRL, 32'h0000_0000);
      bus_write(ADDR_COMMIT, 32'h0);
      while (ncyc < cmt_b + FRAME) probe_disp("disable");
      bus_read(ADDR_COMMIT, "status_scan_a");
      repeat (10) @(posedge HCLK);
      #1;
      bus_read(ADDR_COMMIT, "status_scan_b");

      repeat (2) @(posedge HCLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
